// File: rtl/program_memory_pkg.sv
// Shared types and constants for the program memory block.
// No logic; the state enum, NOP opcode and NOP word builder live here.
// No flow control.
package program_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [5:0] NOP_OPC = 6'd46;

    // NOP opcode in the top field, zero operand; callers truncate to their width.
    function automatic logic [63:0] nop_word(input int unsigned data_w, input int unsigned opc_w);
        return 64'(NOP_OPC) << (data_w - opc_w);
    endfunction

endpackage

// File: rtl/prog_ram_sdp.sv
// Simple dual-port instruction store: one synchronous write port, one registered read port.
// Latency: read data one cycle after rd_en; rd_data holds while rd_en is low.
// Backpressure: none, every enabled access completes.
module prog_ram_sdp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/program_memory.sv
// Program store with a streamed loader (IDLE/LOAD/RUN) and a gated instruction fetch port.
// Latency: fetch result one cycle after rd_en; load words written the cycle they are accepted.
// Backpressure: ld_ready drops once the write pointer reaches DEPTH; later words are dropped.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int OPC_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              addr_err,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err
);

    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(nop_word(DATA_W, OPC_W));
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W:0]   ptr_inc;
    logic              wr_en;
    logic              run_fetch;
    logic              fetch_ok;
    logic              sel_ram;
    logic [DATA_W-1:0] ram_rd_data;

    assign ptr_inc   = ptr + 1'b1;
    assign wr_en     = ld_valid && ld_ready;
    assign run_fetch = rd_en && (state == ST_RUN);
    assign fetch_ok  = run_fetch && ({1'b0, rd_addr} < DEPTH_L);

    // ld_ready is kept equal to (state == LOAD && ptr < DEPTH) so it doubles as the in-range flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            ld_count <= '0;
            ld_err   <= 1'b0;
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (ld_start) begin
                        state    <= ST_LOAD;
                        ptr      <= {1'b0, ld_base};
                        ld_count <= '0;
                        ld_err   <= 1'b0;
                        ld_ready <= ({1'b0, ld_base} < DEPTH_L);
                        ld_busy  <= 1'b1;
                        ld_done  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        if (ld_ready) begin
                            ptr      <= ptr_inc;
                            ld_count <= ld_count + 1'b1;
                            ld_ready <= !ld_last && (ptr_inc < DEPTH_L);
                            if (ld_last) begin
                                state   <= ST_RUN;
                                ld_busy <= 1'b0;
                                ld_done <= 1'b1;
                            end
                        end else begin
                            // Overflow: drop the word, wait for the end of the stream.
                            ld_err <= 1'b1;
                            if (ld_last) begin
                                state   <= ST_IDLE;
                                ld_busy <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ld_ready <= 1'b0;
                    ld_busy  <= 1'b0;
                    ld_done  <= 1'b0;
                end
            endcase
        end
    end

    // sel_ram picks the RAM read register or the NOP word; both hold while rd_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_ram     <= 1'b0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            instr_valid <= fetch_ok;
            addr_err    <= run_fetch && !fetch_ok;
            if (rd_en) begin
                sel_ram <= fetch_ok;
            end
        end
    end

    assign instr_out = sel_ram ? ram_rd_data : NOP_WORD;

    prog_ram_sdp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ptr[ADDR_W-1:0]),
        .wr_data (ld_data),
        .rd_en   (fetch_ok),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: two instances (DEPTH 256 and 200) share one stimulus stream
// and are checked every cycle against a transaction-level model of the loader and fetch rules.
module tb_program_memory;

    localparam logic [15:0] NOP = 16'hB800;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        ld_start = 1'b0;
    logic [7:0]  ld_base = '0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_last = 1'b0;

    logic [15:0] instr_out   [2];
    logic        instr_valid [2];
    logic        addr_err    [2];
    logic        ld_ready    [2];
    logic [8:0]  ld_count    [2];
    logic        ld_busy     [2];
    logic        ld_done     [2];
    logic        ld_err      [2];

    int checks = 0;
    int errors = 0;

    // Model state per instance
    int          phase  [2];
    int          m_base [2];
    int          m_cnt  [2];
    bit          m_err  [2];
    logic [15:0] mem    [2][256];
    bit          known  [2][256];
    logic [15:0] e_instr[2];
    bit          e_known[2];
    bit          e_valid[2];
    bit          e_aerr [2];

    always #5 clk = ~clk;

    program_memory dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .instr_out(instr_out[0]), .instr_valid(instr_valid[0]), .addr_err(addr_err[0]),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready[0]), .ld_count(ld_count[0]),
        .ld_busy(ld_busy[0]), .ld_done(ld_done[0]), .ld_err(ld_err[0])
    );

    program_memory #(.DEPTH(200)) dut_s (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .instr_out(instr_out[1]), .instr_valid(instr_valid[1]), .addr_err(addr_err[1]),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready[1]), .ld_count(ld_count[1]),
        .ld_busy(ld_busy[1]), .ld_done(ld_done[1]), .ld_err(ld_err[1])
    );

    function automatic int dep(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            phase[k]   = P_IDLE;
            m_base[k]  = 0;
            m_cnt[k]   = 0;
            m_err[k]   = 1'b0;
            e_instr[k] = NOP;
            e_known[k] = 1'b1;
            e_valid[k] = 1'b0;
            e_aerr[k]  = 1'b0;
        end
    endfunction

    // Effect of one rising edge on instance k, given the inputs currently applied.
    function automatic void model_edge(input int k);
        int d = dep(k);
        e_valid[k] = 1'b0;
        e_aerr[k]  = 1'b0;
        if (rd_en) begin
            if (phase[k] != P_RUN) begin
                e_instr[k] = NOP;
                e_known[k] = 1'b1;
            end else if (int'(rd_addr) >= d) begin
                e_instr[k] = NOP;
                e_known[k] = 1'b1;
                e_aerr[k]  = 1'b1;
            end else begin
                e_instr[k] = mem[k][rd_addr];
                e_known[k] = known[k][rd_addr];
                e_valid[k] = 1'b1;
            end
        end
        if (phase[k] == P_LOAD) begin
            if (ld_valid) begin
                if (m_base[k] + m_cnt[k] < d) begin
                    mem[k][m_base[k] + m_cnt[k]]   = ld_data;
                    known[k][m_base[k] + m_cnt[k]] = 1'b1;
                    m_cnt[k]++;
                    if (ld_last) phase[k] = P_RUN;
                end else begin
                    m_err[k] = 1'b1;
                    if (ld_last) phase[k] = P_IDLE;
                end
            end
        end else if (ld_start) begin
            phase[k]  = P_LOAD;
            m_base[k] = int'(ld_base);
            m_cnt[k]  = 0;
            m_err[k]  = 1'b0;
        end
    endfunction

    task automatic check_outputs(input int k);
        check($sformatf("busy%0d", k),  32'(ld_busy[k]),  32'(phase[k] == P_LOAD));
        check($sformatf("done%0d", k),  32'(ld_done[k]),  32'(phase[k] == P_RUN));
        check($sformatf("ready%0d", k), 32'(ld_ready[k]),
              32'(phase[k] == P_LOAD && (m_base[k] + m_cnt[k] < dep(k))));
        check($sformatf("count%0d", k), 32'(ld_count[k]), 32'(m_cnt[k]));
        check($sformatf("err%0d", k),   32'(ld_err[k]),   32'(m_err[k]));
        check($sformatf("ivalid%0d", k), 32'(instr_valid[k]), 32'(e_valid[k]));
        check($sformatf("aerr%0d", k),  32'(addr_err[k]), 32'(e_aerr[k]));
        if (e_known[k]) check($sformatf("instr%0d", k), 32'(instr_out[k]), 32'(e_instr[k]));
    endtask

    task automatic step();
        for (int k = 0; k < 2; k++) model_edge(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k);
    endtask

    task automatic do_reset();
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) check_outputs(k);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fetch(input int addr);
        rd_en   = 1'b1;
        rd_addr = 8'(addr);
        step();
        rd_en   = 1'b0;
    endtask

    // Streams n words from base; every cycle with ld_valid high consumes one word.
    task automatic load(input int base, input int n, input int vld_pct, input bit rnd_data,
                        input int abort_after);
        int i = 0;
        int guard = 0;
        ld_start = 1'b1;
        ld_base  = 8'(base);
        rd_en    = 1'b0;
        step();
        while (i < n && guard < 5000) begin
            if (abort_after >= 0 && i >= abort_after) break;
            ld_valid = ($urandom_range(99) < vld_pct);
            ld_data  = rnd_data ? 16'($urandom) : 16'(16'h0400 + i);
            ld_last  = (i == n - 1);
            ld_start = ($urandom_range(7) == 0);
            ld_base  = 8'($urandom);
            rd_en    = 1'($urandom_range(1));
            rd_addr  = 8'($urandom);
            step();
            if (ld_valid) i++;
            guard++;
        end
        if (abort_after < 0 && i < n) check("load_stall", 32'(i), 32'(n));
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0; rd_en = 1'b0;
        step();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Fetch before any program is loaded
        fetch(56);
        check("req037_instr", 32'(instr_out[0]), 32'h0000_B800);
        check("req037_valid", 32'(instr_valid[0]), 32'd0);

        // 165 words from base 0 with fixed pattern
        load(0, 165, 100, 1'b0, -1);
        check("req036_count", 32'(ld_count[0]), 32'd165);
        check("req036_done", 32'(ld_done[0]), 32'd1);
        fetch(56);
        check("req036_instr", 32'(instr_out[0]), 32'h0000_0438);
        check("req036_valid", 32'(instr_valid[0]), 32'd1);

        // Out-of-range fetch on the DEPTH=200 instance
        fetch(255);
        check("req038_instr", 32'(instr_out[1]), 32'h0000_B800);
        check("req038_valid", 32'(instr_valid[1]), 32'd0);
        check("req038_aerr", 32'(addr_err[1]), 32'd1);
        step();
        check("req038_pulse", 32'(addr_err[1]), 32'd0);
        fetch(199);
        fetch(200);
        check("depth_edge_aerr", 32'(addr_err[1]), 32'd1);

        // Random fetch traffic in RUN, including idle cycles that must hold instr_out
        for (int c = 0; c < 60; c++) begin
            rd_en   = 1'($urandom_range(1));
            rd_addr = 8'($urandom);
            step();
        end
        rd_en = 1'b0;

        // Overflow: base 250, 10 words
        load(250, 10, 100, 1'b0, -1);
        check("req039_count", 32'(ld_count[0]), 32'd6);
        check("req039_err", 32'(ld_err[0]), 32'd1);
        check("req039_busy", 32'(ld_busy[0]), 32'd0);
        check("req039_done", 32'(ld_done[0]), 32'd0);
        fetch(251);
        check("req039_nop", 32'(instr_out[0]), 32'h0000_B800);

        // Reset in the middle of a 50-word load
        load(0, 50, 100, 1'b1, 20);
        do_reset();
        check("req040_count", 32'(ld_count[0]), 32'd0);
        fetch(7);
        check("req040_nop", 32'(instr_out[0]), 32'h0000_B800);
        check("req040_valid", 32'(instr_valid[0]), 32'd0);

        // 64 random words from base 16 with ld_valid at 50%, then read all back
        load(16, 64, 50, 1'b1, -1);
        check("req041_count", 32'(ld_count[0]), 32'd64);
        for (int a = 16; a < 80; a++) fetch(a);

        for (int c = 0; c < 40; c++) begin
            rd_en   = 1'($urandom_range(1));
            rd_addr = 8'($urandom_range(96));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
